seq_shifter: RTL and testbench

- Parametrised, multi-cycle successor to the datapath 16-bit combinational shifter.
- Shifts a WIDTH-bit operand by a variable amount using an iterative engine of STEP bits per cycle.
- Supports logical left, logical right and arithmetic right shifts, plus carry and zero flags.
- Connects to the execute stage with valid/ready handshakes on both sides.

---
 rtl/shifter_pkg.sv | 25 ++
 rtl/shift_step.sv | 62 ++++++
 rtl/seq_shifter.sv | 108 ++++++++++
 tb/tb_seq_shifter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared mode/state types and per-cycle step sizing for seq_shifter
package shifter_pkg;

  typedef enum logic [2:0] {
    SH_PASS = 3'b000,
    SH_LSL  = 3'b001,
    SH_LSR  = 3'b010,
    SH_ASR  = 3'b011,
    SH_ROR  = 3'b100,
    SH_ROL  = 3'b101
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } seq_shifter_state_e;

  // Bits to shift this cycle: the smaller of what is left and the engine step.
  function automatic int unsigned step_amount(input int unsigned remaining,
                                              input int unsigned step);
    return (remaining < step) ? remaining : step;
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shifter; rotates only with SEQ_SHIFTER_ROTATE_EN
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KW    = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  // One guard bit beside the operand catches the last bit shifted out.
  logic [WIDTH:0]        ext_l;
  logic [WIDTH:0]        ext_r;
  logic signed [WIDTH:0] ext_a;
`ifdef SEQ_SHIFTER_ROTATE_EN
  logic [KW:0]           back;
`endif

  always_comb begin
    result = data;
    carry  = 1'b0;
    ext_l  = {1'b0, data} << k;
    ext_r  = {data, 1'b0} >> k;
    ext_a  = $signed({data, 1'b0}) >>> k;
`ifdef SEQ_SHIFTER_ROTATE_EN
    back   = (KW+1)'(WIDTH) - {1'b0, k};
`endif
    case (mode)
      SH_LSL: begin
        result = ext_l[WIDTH-1:0];
        carry  = ext_l[WIDTH];
      end
      SH_LSR: begin
        result = ext_r[WIDTH:1];
        carry  = ext_r[0];
      end
      SH_ASR: begin
        result = ext_a[WIDTH:1];
        carry  = ext_a[0];
      end
`ifdef SEQ_SHIFTER_ROTATE_EN
      SH_ROR: begin
        result = (data >> k) | (data << back);
        carry  = result[WIDTH-1];
      end
      SH_ROL: begin
        result = (data << k) | (data >> back);
        carry  = result[0];
      end
`endif
      default: begin
        result = data;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - iterative STEP-bits-per-cycle shifter; rotate modes with SEQ_SHIFTER_ROTATE_EN
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int          WIDTH   = 16,
  parameter int unsigned STEP    = 1,
  parameter int          SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               out_zero
);

  seq_shifter_state_e state;
  logic [SHAMT_W-1:0] rem_q;
  logic [2:0]         mode_q;
  logic [SHAMT_W-1:0] k;
  logic [WIDTH-1:0]   step_data;
  logic               step_carry;
  logic               shiftable;

  assign k        = SHAMT_W'(step_amount(32'(rem_q), STEP));
  assign out_zero = (out_data == '0);

  always_comb begin
    shiftable = 1'b0;
    case (in_mode)
      SH_LSL, SH_LSR, SH_ASR: shiftable = 1'b1;
`ifdef SEQ_SHIFTER_ROTATE_EN
      SH_ROR, SH_ROL:         shiftable = 1'b1;
`endif
      default:                shiftable = 1'b0;
    endcase
  end

  shift_step #(
    .WIDTH (WIDTH),
    .KW    (SHAMT_W)
  ) u_step (
    .data   (out_data),
    .k      (k),
    .mode   (mode_q),
    .result (step_data),
    .carry  (step_carry)
  );

  // out_data doubles as the working register while shifting; out_valid masks it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      rem_q     <= '0;
      mode_q    <= SH_PASS;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_data  <= in_data;
            out_carry <= 1'b0;
            mode_q    <= in_mode;
            rem_q     <= in_shamt;
            in_ready  <= 1'b0;
            if (shiftable && in_shamt != '0) begin
              state <= SHIFT;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          out_data  <= step_data;
          out_carry <= step_carry;
          rem_q     <= rem_q - k;
          if (rem_q == k) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - directed checks of seq_shifter at STEP=1 and STEP=4
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid1, in_valid4;
  logic [15:0] in_data;
  logic [3:0]  in_shamt;
  logic [2:0]  in_mode;
  logic        out_ready;

  logic        in_ready1, out_valid1, out_carry1, out_zero1;
  logic [15:0] out_data1;
  logic        in_ready4, out_valid4, out_carry4, out_zero4;
  logic [15:0] out_data4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_carry(out_carry1), .out_zero(out_zero1)
  );

  seq_shifter #(.WIDTH(16), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_carry(out_carry4), .out_zero(out_zero4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one request to the STEP=1 (s4=0) or STEP=4 (s4=1) instance and check it.
  task automatic run_op(input string tag, input bit s4, input logic [15:0] d,
                        input logic [3:0] sh, input logic [2:0] m,
                        input logic [15:0] ed, input bit ec, input int en, input int hold);
    int cyc;
    chk({tag, ".in_ready"}, s4 ? in_ready4 : in_ready1, 1);
    in_data  = d;
    in_shamt = sh;
    in_mode  = m;
    if (s4) in_valid4 = 1'b1; else in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    in_valid4 = 1'b0;
    in_data   = 16'hA5A5;
    in_shamt  = 4'd7;
    in_mode   = 3'b001;
    if (en > 0) chk({tag, ".busy"}, s4 ? in_ready4 : in_ready1, 0);
    cyc = 0;
    while (!(s4 ? out_valid4 : out_valid1) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, ".latency"}, cyc, en);
    chk({tag, ".data"},  s4 ? out_data4  : out_data1,  ed);
    chk({tag, ".carry"}, s4 ? out_carry4 : out_carry1, ec);
    chk({tag, ".zero"},  s4 ? out_zero4  : out_zero1,  (ed == 16'h0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, s4 ? out_valid4 : out_valid1, 1);
      chk({tag, ".hold_ready"}, s4 ? in_ready4  : in_ready1,  0);
      chk({tag, ".hold_data"},  s4 ? out_data4  : out_data1,  ed);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".drain"}, s4 ? out_valid4 : out_valid1, 0);
    chk({tag, ".retain"}, s4 ? out_data4 : out_data1, ed);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid1 = 1'b0;
    in_valid4 = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst.in_ready",  in_ready1,  1);
    chk("rst.out_valid", out_valid1, 0);
    chk("rst.out_data",  out_data1,  0);
    chk("rst.out_carry", out_carry1, 0);
    chk("rst.out_zero",  out_zero1,  1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("lsl1",     0, 16'h8001, 4'd1,  3'b001, 16'h0002, 1, 1,  0);
    run_op("asr15",    0, 16'h8000, 4'd15, 3'b011, 16'hFFFF, 0, 15, 0);
    run_op("lsr15",    0, 16'h8000, 4'd15, 3'b010, 16'h0001, 0, 15, 0);
    run_op("s4_lsr6",  1, 16'h00F0, 4'd6,  3'b010, 16'h0003, 1, 2,  0);
    run_op("s4_lsl12", 1, 16'h00F0, 4'd12, 3'b001, 16'h0000, 1, 3,  0);
    run_op("s4_asr7",  1, 16'h8421, 4'd7,  3'b011, 16'hFF08, 0, 2,  0);
    run_op("pass",     0, 16'h1234, 4'd5,  3'b000, 16'h1234, 0, 0,  5);
    run_op("s4_sh0",   1, 16'h1234, 4'd0,  3'b001, 16'h1234, 0, 0,  0);
    run_op("mode110",  0, 16'h00F0, 4'd3,  3'b110, 16'h00F0, 0, 0,  0);
`ifdef SEQ_SHIFTER_ROTATE_EN
    run_op("ror1",     0, 16'h0001, 4'd1,  3'b100, 16'h8000, 1, 1,  0);
    run_op("s4_rol5",  1, 16'h8001, 4'd5,  3'b101, 16'h0030, 0, 2,  0);
`else
    run_op("ror1",     0, 16'h0001, 4'd1,  3'b100, 16'h0001, 0, 0,  0);
    run_op("s4_rol5",  1, 16'h8001, 4'd5,  3'b101, 16'h8001, 0, 0,  0);
`endif

    // Abort an LSL by 10 mid-shift with an asynchronous reset.
    in_data   = 16'h0003;
    in_shamt  = 4'd10;
    in_mode   = 3'b001;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort.in_ready",  in_ready1,  1);
    chk("abort.out_valid", out_valid1, 0);
    chk("abort.out_data",  out_data1,  0);
    chk("abort.out_zero",  out_zero1,  1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op("after_abort", 0, 16'h0003, 4'd10, 3'b001, 16'h0C00, 0, 10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
